mac_job_sequencer: RTL and testbench
====================================

Name: mac_job_sequencer

Overview:
Sequences one dot-product job at a time through the 8x8->16 MAC datapath. It accepts a job command (length and operand base addresses) and streams weight/activation pairs from two synchronous operand memories into the MAC. It then waits out the MAC pipeline latency and returns the accumulated result over a valid/ready handshake. It sits between the job scheduler and the MAC lane, and owns the MAC's clear and input-valid controls.

Parameters:
DATA_W, 8, operand width (weights and activations)
ACC_W, 16, accumulator/result width
ADDR_W, 8, operand memory address width
LEN_W, 8, job length field width (0..2^LEN_W-1 pairs)
MAC_LATENCY, 3, cycles from a valid MAC input to its contribution being visible on mac_acc

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  job command valid
cmd_ready  out  1  high only in IDLE
cmd_len  in  LEN_W  number of operand pairs
cmd_base_w  in  ADDR_W  weight base address
cmd_base_a  in  ADDR_W  activation base address
mem_rd_en  out  1  read strobe, both memories
mem_rd_addr_w  out  ADDR_W  weight read address
mem_rd_addr_a  out  ADDR_W  activation read address
mem_rd_data_w  in  DATA_W  weight data, valid 1 cycle after mem_rd_en
mem_rd_data_a  in  DATA_W  activation data, valid 1 cycle after mem_rd_en
mac_clear  out  1  one-cycle accumulator clear
mac_in_valid  out  1  operands on mac_weights/mac_activations are valid
mac_weights  out  DATA_W  = mem_rd_data_w (pass-through)
mac_activations  out  DATA_W  = mem_rd_data_a (pass-through)
mac_acc  in  ACC_W  MAC accumulator value
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_data  out  ACC_W  captured result
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, active-high): state goes to IDLE. All outputs are 0 except cmd_ready, which is 1 from the first cycle after reset deasserts. Reset mid-job aborts immediately. No clear or drain is issued; the next job's CLEAR handles MAC state.
- FSM states: IDLE -> CLEAR -> FETCH -> DRAIN -> DONE -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready at cycle T, latch len and both bases, and zero the index.
- CLEAR (cycle T+1): mac_clear=1 for exactly one cycle. If len=0, go to DONE with res_data=0 and no memory reads. Otherwise go to FETCH.
- FETCH (cycles T+2..T+1+N):
  - mem_rd_en=1.
  - Address = base + i, for i = 0..N-1, computed modulo 2^ADDR_W (wraps).
  - Exit to DRAIN after issuing i=N-1.
- mac_in_valid is mem_rd_en registered by one cycle. Its pair therefore occupies cycles T+3..T+2+N.
- DRAIN:
  - Counter runs for MAC_LATENCY+1 cycles (T+2+N..T+2+N+MAC_LATENCY).
  - On the last DRAIN cycle, register mac_acc into res_data and go to DONE.
- DONE:
  - res_valid=1, and res_data is held stable until res_ready.
  - On res_valid&res_ready, go to IDLE, deassert res_valid, and set cmd_ready=1 in the next cycle.
  - No new command is accepted in the same cycle as the result handshake.
- Latency:
  - len>0: res_valid first high at T+N+MAC_LATENCY+3.
  - len=0: res_valid first high at T+2.
- Arithmetic: the sequencer does no arithmetic on data. Accumulator wrap modulo 2^ACC_W is the MAC's behaviour, passed through unchanged. The index counter is LEN_W+1 bits wide to avoid terminal-count aliasing at max len.
- cmd_* inputs are ignored outside IDLE. mem_rd_data_* values are don't-care when mac_in_valid=0.

Decomposition:
- Shared package mac_pkg holds:
  - seq_state_t enum (IDLE, CLEAR, FETCH, DRAIN, DONE);
  - DATA_W, ACC_W, and default MAC_LATENCY constants, shared with the MAC datapath.
- One natural sub-module, mac_operand_fetch. It holds the base/index address generator, the mem_rd_en strobe and the one-cycle mac_in_valid delay, and takes start, len and bases as inputs with a done output.
- FSM, drain counter and result register stay in the top module.

Test Plan:
- Bench MAC model is an exact multiply-accumulate with MAC_LATENCY=3. Memory model has 1-cycle read latency.
1. len=4, w=[1,2,3,4], a=[5,6,7,8], res_ready=1 -> res_data=70, res_valid first at T+10; 4 mem_rd_en cycles; 4 mac_in_valid cycles; one mac_clear at T+1.
2. len=0 -> mac_clear at T+1, zero mem_rd_en and mac_in_valid cycles, res_valid at T+2 with res_data=0.
3. len=2, w=[255,255], a=[255,255] -> res_data=64514 (130050 mod 65536).
4. base_w=0xFE, base_a=0x10, len=4 -> mem_rd_addr_w = FE,FF,00,01 and mem_rd_addr_a = 10,11,12,13 on consecutive cycles.
5. Job 1 completes with res_ready low for 5 cycles -> res_valid and res_data stable, cmd_ready=0, busy=1 throughout. cmd_valid held high is accepted only the cycle after the handshake. Job 2 result excludes job 1's sum.
6. reset pulsed during the 3rd FETCH cycle of a len=8 job -> next cycle all outputs 0 and cmd_ready=1. Follow-up job len=2, w=[3,4], a=[5,6] gives res_data=39.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and default widths for the MAC lane and its job sequencer.
package mac_pkg;

    localparam int unsigned MacDataW   = 8;
    localparam int unsigned MacAccW    = 16;
    localparam int unsigned MacLatency = 3;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFetch,
        StDrain,
        StDone
    } seq_state_t;

endpackage

// File: rtl/mac_operand_fetch.sv
// Operand address generator: walks base+i for len pairs, issues read strobes,
// and delays the strobe by one cycle to mark MAC input validity.
module mac_operand_fetch #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [ADDR_W-1:0] base_w_i,
    input  logic [ADDR_W-1:0] base_a_i,
    output logic              mem_rd_en_o,
    output logic [ADDR_W-1:0] mem_rd_addr_w_o,
    output logic [ADDR_W-1:0] mem_rd_addr_a_o,
    output logic              mac_in_valid_o,
    output logic              done_o
);

    // One extra bit so idx+1 never aliases to zero at the maximum length.
    logic [LEN_W:0] idx_q, idx_d;
    logic           active_q, active_d;
    logic           in_valid_q;
    logic           last;

    assign last = ((idx_q + (LEN_W + 1)'(1)) == {1'b0, len_i});

    always_comb begin
        idx_d    = idx_q;
        active_d = active_q;
        done_o   = 1'b0;
        if (start_i) begin
            idx_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            idx_d = idx_q + (LEN_W + 1)'(1);
            if (last) begin
                active_d = 1'b0;
                done_o   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q      <= '0;
            active_q   <= 1'b0;
            in_valid_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            active_q   <= active_d;
            in_valid_q <= active_q;
        end
    end

    assign mem_rd_en_o     = active_q;
    assign mem_rd_addr_w_o = active_q ? base_w_i + ADDR_W'(idx_q) : '0;
    assign mem_rd_addr_a_o = active_q ? base_a_i + ADDR_W'(idx_q) : '0;
    assign mac_in_valid_o  = in_valid_q;

endmodule

// File: rtl/mac_job_sequencer.sv
// Runs one dot-product job through the MAC lane: clear, stream operands,
// wait out the pipeline, then hand back the accumulated result.
module mac_job_sequencer
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W      = MacDataW,
    parameter int unsigned ACC_W       = MacAccW,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned MAC_LATENCY = MacLatency
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ADDR_W-1:0] cmd_base_w,
    input  logic [ADDR_W-1:0] cmd_base_a,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr_w,
    output logic [ADDR_W-1:0] mem_rd_addr_a,
    input  logic [DATA_W-1:0] mem_rd_data_w,
    input  logic [DATA_W-1:0] mem_rd_data_a,
    output logic              mac_clear,
    output logic              mac_in_valid,
    output logic [DATA_W-1:0] mac_weights,
    output logic [DATA_W-1:0] mac_activations,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              busy
);

    localparam int unsigned DrainW = $clog2(MAC_LATENCY + 1) + 1;

    seq_state_t        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W-1:0] base_w_q, base_w_d;
    logic [ADDR_W-1:0] base_a_q, base_a_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic [ACC_W-1:0]  res_q, res_d;
    logic              fetch_start;
    logic              fetch_done;

    mac_operand_fetch #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_fetch (
        .clk             (clk),
        .reset           (reset),
        .start_i         (fetch_start),
        .len_i           (len_q),
        .base_w_i        (base_w_q),
        .base_a_i        (base_a_q),
        .mem_rd_en_o     (mem_rd_en),
        .mem_rd_addr_w_o (mem_rd_addr_w),
        .mem_rd_addr_a_o (mem_rd_addr_a),
        .mac_in_valid_o  (mac_in_valid),
        .done_o          (fetch_done)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        base_w_d    = base_w_q;
        base_a_d    = base_a_q;
        drain_d     = drain_q;
        res_d       = res_q;
        fetch_start = 1'b0;
        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    len_d    = cmd_len;
                    base_w_d = cmd_base_w;
                    base_a_d = cmd_base_a;
                    state_d  = StClear;
                end
            end
            StClear: begin
                if (len_q == '0) begin
                    res_d   = '0;
                    state_d = StDone;
                end else begin
                    fetch_start = 1'b1;
                    state_d     = StFetch;
                end
            end
            StFetch: begin
                if (fetch_done) begin
                    drain_d = '0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Last pair's contribution lands on mac_acc MAC_LATENCY cycles later.
                if (drain_q == DrainW'(MAC_LATENCY)) begin
                    res_d   = mac_acc;
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + DrainW'(1);
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            len_q    <= '0;
            base_w_q <= '0;
            base_a_q <= '0;
            drain_q  <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            base_w_q <= base_w_d;
            base_a_q <= base_a_d;
            drain_q  <= drain_d;
            res_q    <= res_d;
        end
    end

    assign cmd_ready       = (state_q == StIdle);
    assign busy            = (state_q != StIdle);
    assign mac_clear       = (state_q == StClear);
    assign res_valid       = (state_q == StDone);
    assign res_data        = res_q;
    assign mac_weights     = mem_rd_data_w;
    assign mac_activations = mem_rd_data_a;

endmodule

// File: tb/tb_mac_job_sequencer.sv
// Directed bench: synchronous operand memories plus an exact 3-stage MAC model.
module tb_mac_job_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic [7:0]  cmd_base_w;
    logic [7:0]  cmd_base_a;
    logic        mem_rd_en;
    logic [7:0]  mem_rd_addr_w;
    logic [7:0]  mem_rd_addr_a;
    logic [7:0]  mem_rd_data_w;
    logic [7:0]  mem_rd_data_a;
    logic        mac_clear;
    logic        mac_in_valid;
    logic [7:0]  mac_weights;
    logic [7:0]  mac_activations;
    logic [15:0] mac_acc;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        busy;

    always #5 clk = ~clk;

    mac_job_sequencer u_dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_len         (cmd_len),
        .cmd_base_w      (cmd_base_w),
        .cmd_base_a      (cmd_base_a),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr_w   (mem_rd_addr_w),
        .mem_rd_addr_a   (mem_rd_addr_a),
        .mem_rd_data_w   (mem_rd_data_w),
        .mem_rd_data_a   (mem_rd_data_a),
        .mac_clear       (mac_clear),
        .mac_in_valid    (mac_in_valid),
        .mac_weights     (mac_weights),
        .mac_activations (mac_activations),
        .mac_acc         (mac_acc),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_data        (res_data),
        .busy            (busy)
    );

    // Operand memories, one-cycle read latency.
    logic [7:0] wmem [256];
    logic [7:0] amem [256];
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data_w <= wmem[mem_rd_addr_w];
            mem_rd_data_a <= amem[mem_rd_addr_a];
        end
    end

    // MAC: input in cycle c is visible on mac_acc in cycle c+3.
    logic [15:0] acc_m, pipe0, pipe1;
    always @(posedge clk) begin
        if (mac_clear) acc_m <= 16'd0;
        else if (mac_in_valid) acc_m <= acc_m + 16'(mac_weights * mac_activations);
        pipe0 <= acc_m;
        pipe1 <= pipe0;
    end
    assign mac_acc = pipe1;

    int cyc = 0, n_rd = 0, n_iv = 0, n_clr = 0, n_acc = 0, acc_cyc = 0, clr_cyc = 0;
    logic [7:0] aw_log [64];
    logic [7:0] aa_log [64];
    int         rd_cyc_log [64];

    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_valid && cmd_ready) begin
                n_acc++;
                acc_cyc = cyc;
            end
            if (mac_clear) begin
                n_clr++;
                clr_cyc = cyc;
            end
            if (mac_in_valid) n_iv++;
            if (mem_rd_en) begin
                aw_log[n_rd & 63]     = mem_rd_addr_w;
                aa_log[n_rd & 63]     = mem_rd_addr_a;
                rd_cyc_log[n_rd & 63] = cyc;
                n_rd++;
            end
        end
        cyc++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Issues one command from posedge+1 and returns at the first res_valid cycle.
    task automatic run_job(input logic [7:0] len, input logic [7:0] bw, input logic [7:0] ba,
                           output int lat, output logic [15:0] res);
        cmd_valid  = 1'b1;
        cmd_len    = len;
        cmd_base_w = bw;
        cmd_base_a = ba;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = res_data;
        if (res_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    int          lat, b_rd, b_iv, b_clr, b_acc, k;
    logic [15:0] res;

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_len    = '0;
        cmd_base_w = '0;
        cmd_base_a = '0;
        res_ready  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            wmem[i] = 8'd0;
            amem[i] = 8'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mac_clear", mac_clear, 0);
        check("rst_mac_in_valid", mac_in_valid, 0);

        // Job 1: len=4, 1*5+2*6+3*7+4*8 = 70
        for (int i = 0; i < 4; i++) begin
            wmem[i]        = 8'(i + 1);
            amem[8'h40 + i] = 8'(i + 5);
        end
        res_ready = 1'b1;
        b_rd = n_rd; b_iv = n_iv; b_clr = n_clr;
        run_job(8'd4, 8'h00, 8'h40, lat, res);
        check("j1_res", res, 70);
        check("j1_latency", lat, 10);
        check("j1_rd_cnt", n_rd - b_rd, 4);
        check("j1_iv_cnt", n_iv - b_iv, 4);
        check("j1_clr_cnt", n_clr - b_clr, 1);
        check("j1_clr_cycle", clr_cyc - acc_cyc, 1);
        check("j1_first_rd_cycle", rd_cyc_log[b_rd & 63] - acc_cyc, 2);
        check("j1_idle_after", cmd_ready, 1);
        check("j1_res_valid_drop", res_valid, 0);

        // Job 2: len=0
        b_rd = n_rd; b_iv = n_iv; b_clr = n_clr;
        run_job(8'd0, 8'h00, 8'h40, lat, res);
        check("j0_res", res, 0);
        check("j0_latency", lat, 2);
        check("j0_rd_cnt", n_rd - b_rd, 0);
        check("j0_iv_cnt", n_iv - b_iv, 0);
        check("j0_clr_cnt", n_clr - b_clr, 1);
        check("j0_clr_cycle", clr_cyc - acc_cyc, 1);

        // Job 3: 2*255*255 = 130050 -> 64514
        wmem[8'h20] = 8'd255; wmem[8'h21] = 8'd255;
        amem[8'h60] = 8'd255; amem[8'h61] = 8'd255;
        run_job(8'd2, 8'h20, 8'h60, lat, res);
        check("jwrap_res", res, 64514);
        check("jwrap_latency", lat, 8);

        // Job 4: address wrap, 1*1+1*2+1*3+1*4 = 10
        wmem[8'hFE] = 8'd1; wmem[8'hFF] = 8'd1; wmem[8'h00] = 8'd1; wmem[8'h01] = 8'd1;
        for (int i = 0; i < 4; i++) amem[8'h10 + i] = 8'(i + 1);
        b_rd = n_rd;
        run_job(8'd4, 8'hFE, 8'h10, lat, res);
        check("jaddr_res", res, 10);
        check("jaddr_rd_cnt", n_rd - b_rd, 4);
        check("jaddr_w0", aw_log[(b_rd + 0) & 63], 8'hFE);
        check("jaddr_w1", aw_log[(b_rd + 1) & 63], 8'hFF);
        check("jaddr_w2", aw_log[(b_rd + 2) & 63], 8'h00);
        check("jaddr_w3", aw_log[(b_rd + 3) & 63], 8'h01);
        for (int i = 0; i < 4; i++)
            check("jaddr_a", aa_log[(b_rd + i) & 63], 32'h10 + i);
        check("jaddr_span", rd_cyc_log[(b_rd + 3) & 63] - rd_cyc_log[b_rd & 63], 3);

        // Job 5: backpressure; 2*4+3*5 = 23, then queued job 10*10 = 100
        wmem[8'h80] = 8'd2; wmem[8'h81] = 8'd3;
        amem[8'hC0] = 8'd4; amem[8'hC1] = 8'd5;
        wmem[8'h90] = 8'd10; amem[8'hA0] = 8'd10;
        res_ready = 1'b0;
        run_job(8'd2, 8'h80, 8'hC0, lat, res);
        check("bp_res", res, 23);
        cmd_valid  = 1'b1;
        cmd_len    = 8'd1;
        cmd_base_w = 8'h90;
        cmd_base_a = 8'hA0;
        b_acc = n_acc;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", res_valid, 1);
            check("bp_hold_data", res_data, 23);
            check("bp_hold_cmd_ready", cmd_ready, 0);
            check("bp_hold_busy", busy, 1);
        end
        check("bp_no_accept", n_acc - b_acc, 0);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_post_hs_valid", res_valid, 0);
        check("bp_post_hs_ready", cmd_ready, 1);
        check("bp_hs_no_accept", n_acc - b_acc, 0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("bp_accept_next", n_acc - b_acc, 1);
        check("bp_busy_j2", busy, 1);
        k = 0;
        while (!res_valid && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("bp_j2_res", res_data, 100);
        @(posedge clk);
        #1;

        // Job 6: reset during the third FETCH cycle of a len=8 job
        for (int i = 0; i < 8; i++) begin
            wmem[i] = 8'd7;
            amem[i] = 8'd9;
        end
        cmd_valid  = 1'b1;
        cmd_len    = 8'd8;
        cmd_base_w = 8'h00;
        cmd_base_a = 8'h00;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("abort_in_fetch", mem_rd_en, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_rd_en", mem_rd_en, 0);
        check("abort_addr_w", mem_rd_addr_w, 0);
        check("abort_addr_a", mem_rd_addr_a, 0);
        check("abort_iv", mac_in_valid, 0);
        check("abort_clear", mac_clear, 0);
        check("abort_res_valid", res_valid, 0);
        check("abort_res_data", res_data, 0);
        wmem[0] = 8'd3; wmem[1] = 8'd4;
        amem[0] = 8'd5; amem[1] = 8'd6;
        run_job(8'd2, 8'h00, 8'h00, lat, res);
        check("abort_followup_res", res, 39);
        check("abort_followup_lat", lat, 8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog timeout");
    end

endmodule
